// File: rtl/gf22_sram_banked_arb_if.sv
// Write/read port bundle for gf22_sram_banked_arb: requester side is master,
// memory side is slave.
interface gf22_sram_banked_arb_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 19
);
  logic              CE0;
  logic [ADDR_W-1:0] A0;
  logic [DATA_W-1:0] D0;
  logic              WE0;
  logic [DATA_W-1:0] WEM0;
  logic              RDY0;
  logic              CE1;
  logic [ADDR_W-1:0] A1;
  logic              RDY1;
  logic [DATA_W-1:0] Q1;
  logic              QV1;

  modport master (
    output CE0, A0, D0, WE0, WEM0, CE1, A1,
    input  RDY0, RDY1, Q1, QV1
  );

  modport slave (
    input  CE0, A0, D0, WE0, WEM0, CE1, A1,
    output RDY0, RDY1, Q1, QV1
  );
endinterface

// File: rtl/gf22_sram_banked_arb.sv
// 1W/1R banked memory with same-bank collision arbitration (write wins).
// Define GF22_SRAM_RD_AGE_EN to grant a read after MAX_STALL consecutive stalls.
module gf22_sram_banked_arb #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned BANK_AW   = 13,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  gf22_sram_banked_arb_if.slave  bus
);
  localparam int unsigned BSEL_W = (ADDR_W > BANK_AW) ? ADDR_W - BANK_AW : 1;
  localparam int unsigned NBANKS = 1 << (ADDR_W - BANK_AW);

  logic [BSEL_W-1:0] wbank;
  logic [BSEL_W-1:0] rbank;
  logic [BSEL_W-1:0] sel_q;
  logic              qv_q;
  logic              collide;
  logic              rdy0;
  logic              rdy1;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] bank_q [NBANKS];

  if (ADDR_W > BANK_AW) begin : g_bsel
    assign wbank = bus.A0[ADDR_W-1:BANK_AW];
    assign rbank = bus.A1[ADDR_W-1:BANK_AW];
  end else begin : g_bsel_single
    assign wbank = '0;
    assign rbank = '0;
  end

  assign collide = bus.CE0 && bus.WE0 && bus.CE1 && (wbank == rbank);

`ifdef GF22_SRAM_RD_AGE_EN
  localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);
  logic [STALL_W-1:0] stall_q;
  logic               rd_age;

  assign rd_age = (stall_q == STALL_W'(MAX_STALL));

  always_comb begin
    rdy0 = !(collide && rd_age);
    rdy1 = !collide || rd_age;
  end

  // Saturates at MAX_STALL; that value flips collision priority to the read.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      stall_q <= '0;
    end else if (!bus.CE1 || rd_fire) begin
      stall_q <= '0;
    end else if (!rd_age) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end
`else
  logic unused_max_stall;
  assign unused_max_stall = (MAX_STALL == 0);

  always_comb begin
    rdy0 = 1'b1;
    rdy1 = !collide;
  end
`endif

  assign wr_fire  = bus.CE0 && bus.WE0 && rdy0;
  assign rd_fire  = bus.CE1 && rdy1;
  assign bus.RDY0 = rdy0;
  assign bus.RDY1 = rdy1;

  // Arbitration guarantees the write and read winners never target one bank.
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic              w_sel;
    logic              r_sel;
    logic              ce;
    logic              we;
    logic [BANK_AW-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] wem;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] mem [2**BANK_AW];

    assign w_sel = wr_fire && (wbank == BSEL_W'(b));
    assign r_sel = rd_fire && (rbank == BSEL_W'(b));

    always_comb begin
      ce  = w_sel || r_sel;
      we  = w_sel;
      a   = '0;
      d   = '0;
      wem = '0;
      if (w_sel) begin
        a   = bus.A0[BANK_AW-1:0];
        d   = bus.D0;
        wem = bus.WEM0;
      end else if (r_sel) begin
        a = bus.A1[BANK_AW-1:0];
      end
    end

    always_ff @(posedge CLK) begin
      if (ce) begin
        if (we) begin
          mem[a] <= (mem[a] & ~wem) | (d & wem);
        end else begin
          q <= mem[a];
        end
      end
    end

    assign bank_q[b] = q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      qv_q  <= 1'b0;
      sel_q <= '0;
    end else begin
      qv_q <= rd_fire;
      if (rd_fire) begin
        sel_q <= rbank;
      end
    end
  end

  assign bus.QV1 = qv_q;
  assign bus.Q1  = bank_q[sel_q];
endmodule

// File: tb/tb_gf22_sram_banked_arb.sv
// Directed bench for gf22_sram_banked_arb with a queue-based read-data scoreboard.
module tb_gf22_sram_banked_arb;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 19;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mon_exp;

  gf22_sram_banked_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  gf22_sram_banked_arb #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BANK_AW  (13),
    .MAX_STALL(4)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ce0, input logic [18:0] a0, input logic [63:0] d0,
                       input logic we0, input logic [63:0] wem0,
                       input logic ce1, input logic [18:0] a1);
    bus.CE0  = ce0;
    bus.A0   = a0;
    bus.D0   = d0;
    bus.WE0  = we0;
    bus.WEM0 = wem0;
    bus.CE1  = ce1;
    bus.A1   = a1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Check handshakes for the presented request, queue read data, cross one edge.
  task automatic cycle(input string name, input logic exp_r0, input logic exp_r1,
                       input logic [63:0] rd_exp);
    #1;
    if (bus.CE0 && bus.WE0) check({name, "/rdy0"}, 64'(bus.RDY0), 64'(exp_r0));
    if (bus.CE1) begin
      check({name, "/rdy1"}, 64'(bus.RDY1), 64'(exp_r1));
      if (bus.RDY1) exp_q.push_back(rd_exp);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: every QV1 pulse must consume exactly one queued expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (bus.QV1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL qv1_spurious: QV1=1 with Q1=%h, expected no valid", bus.Q1);
        end else begin
          mon_exp = exp_q.pop_front();
          check("q1_data", bus.Q1, mon_exp);
        end
      end
    end
  end

  initial begin
    idle();
    #1;
    check("reset_qv1", 64'(bus.QV1), 64'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;

    // Full write then read back next cycle
    drive(1'b1, 19'h00005, 64'hDEADBEEF_01234567, 1'b1, ONES, 1'b0, '0);
    cycle("wr5", 1'b1, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 19'h00005);
    cycle("rd5", 1'b0, 1'b1, 64'hDEADBEEF_01234567);
    idle_cycles(2);

    // Bit-granular mask merge
    drive(1'b1, 19'h00006, ONES, 1'b1, ONES, 1'b0, '0);
    cycle("pre6", 1'b1, 1'b0, '0);
    drive(1'b1, 19'h00006, 64'd0, 1'b1, 64'h00000000_FFFFFFFF, 1'b0, '0);
    cycle("mask6", 1'b1, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 19'h00006);
    cycle("rd6", 1'b0, 1'b1, 64'hFFFFFFFF_00000000);
    idle_cycles(2);

    // Write bank 1 and read bank 0 in the same cycle
    drive(1'b1, 19'h00010, 64'h11112222_33334444, 1'b1, ONES, 1'b0, '0);
    cycle("pre10", 1'b1, 1'b0, '0);
    drive(1'b1, 19'h02000, 64'hA5A5A5A5_5A5A5A5A, 1'b1, ONES, 1'b1, 19'h00010);
    cycle("parallel", 1'b1, 1'b1, 64'h11112222_33334444);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 19'h02000);
    cycle("rd2000", 1'b0, 1'b1, 64'hA5A5A5A5_5A5A5A5A);
    idle_cycles(2);

    // Top bank at the address-space edge, including a one-cycle collision
    drive(1'b1, 19'h7FFFF, 64'h01234567_89ABCDEF, 1'b1, ONES, 1'b0, '0);
    cycle("wr_top", 1'b1, 1'b0, '0);
    drive(1'b1, 19'h7E000, 64'hFEDCBA98_76543210, 1'b1, ONES, 1'b1, 19'h7FFFF);
    cycle("top_collide", 1'b1, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 19'h7FFFF);
    cycle("rd_top", 1'b0, 1'b1, 64'h01234567_89ABCDEF);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 19'h7E000);
    cycle("rd_top_base", 1'b0, 1'b1, 64'hFEDCBA98_76543210);
    idle_cycles(2);

    // Sustained same-bank collision
    drive(1'b1, 19'h04001, 64'hC0FFEE00_00C0FFEE, 1'b1, ONES, 1'b0, '0);
    cycle("pre4001", 1'b1, 1'b0, '0);
    drive(1'b1, 19'h04000, 64'h55555555_55555555, 1'b1, ONES, 1'b1, 19'h04001);
`ifdef GF22_SRAM_RD_AGE_EN
    for (int i = 0; i < 4; i++) cycle("age_stall", 1'b1, 1'b0, '0);
    cycle("age_grant", 1'b0, 1'b1, 64'hC0FFEE00_00C0FFEE);
    cycle("age_resume", 1'b1, 1'b0, '0);
`else
    for (int i = 0; i < 10; i++) cycle("col_stall", 1'b1, 1'b0, '0);
`endif
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 19'h04001);
    cycle("col_release", 1'b0, 1'b1, 64'hC0FFEE00_00C0FFEE);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 19'h04000);
    cycle("rd4000", 1'b0, 1'b1, 64'h55555555_55555555);
    idle_cycles(2);

    // Reset while a read is in flight: the result must never surface
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 19'h00005);
    #1;
    check("inflight/rdy1", 64'(bus.RDY1), 64'd1);
    @(posedge CLK);
    #1;
    RSTN = 1'b0;
    idle();
    #1;
    check("rst_qv1_clear", 64'(bus.QV1), 64'd0);
    drive(1'b1, 19'h04000, 64'h0, 1'b1, '0, 1'b1, 19'h04005);
    #1;
    check("rst_collide/rdy0", 64'(bus.RDY0), 64'd1);
    check("rst_collide/rdy1", 64'(bus.RDY1), 64'd0);
    idle();
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rst_qv1", 64'(bus.QV1), 64'd0);
    drive(1'b1, 19'h02001, 64'h77777777_77777777, 1'b1, ONES, 1'b1, 19'h00005);
    cycle("post_rst", 1'b1, 1'b1, 64'hDEADBEEF_01234567);
    idle_cycles(3);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
